// File: rtl/mac_accum_seq.sv
// Sequential multiply-accumulate stage: sums COUNT unsigned products per result and
// mirrors its accumulator into a downstream register bank via load/clear/data strobes.
module mac_accum_seq #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int COUNT     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 ovf,
    output logic                 reg_load,
    output logic                 reg_clr,
    output logic [ACC_WIDTH-1:0] reg_d,
    output logic                 dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid never depends on ready, and a presented beat or result is held until taken.

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] result_q, result_d;
    logic                 out_valid_q, out_valid_d;

    logic [2*WIDTH-1:0]   prod;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] sum;
    logic                 carry;
    logic                 fire;

    assign prod     = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign sum_full = {1'b0, acc_q} + {1'b0, ACC_WIDTH'(prod)};
    assign sum      = sum_full[ACC_WIDTH-1:0];
    assign carry    = sum_full[ACC_WIDTH];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        // Strobes are forced low during reset so the bank never sees a stray load.
        in_ready = rst_n & ~clear & (state_q == ACCUM);
        fire     = in_valid & in_ready;
        reg_clr  = rst_n & (clear | ((state_q == DONE) & out_ready));
        reg_load = fire & ~reg_clr;
        reg_d    = rst_n ? sum : '0;

        if (clear) begin
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
            state_d     = ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (fire) begin
                        acc_d = sum;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | carry;
                        if (cnt_q == CNT_LAST) begin
                            result_d    = sum;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

    // A finished result may only be withdrawn by its consumer, a flush or reset.
    a_hold_valid: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q && !out_ready && !clear |=> out_valid_q);
    a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid_q && !out_ready && !clear |=> $stable(result_q));
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(reg_load && reg_clr));

endmodule

// File: tb/tb_mac_accum_seq.sv
// Bench for mac_accum_seq: table vectors and hand sequences on a COUNT=4/16-bit instance,
// a COUNT=1 instance, and randomized traffic scored against a sum-of-products model.
module tb_mac_accum_seq;

    localparam int W     = 8;
    localparam int A_AW  = 16;
    localparam int A_CNT = 4;
    localparam int B_AW  = 20;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: COUNT=4, ACC_WIDTH=16 ----------------
    logic            clear     = 1'b0;
    logic            in_valid  = 1'b0;
    logic            in_ready;
    logic [W-1:0]    a         = '0;
    logic [W-1:0]    b         = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [A_AW-1:0] result;
    logic            ovf;
    logic            reg_load;
    logic            reg_clr;
    logic [A_AW-1:0] reg_d;
    logic            dbg_state;

    mac_accum_seq #(.WIDTH(W), .ACC_WIDTH(A_AW), .COUNT(A_CNT)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .ovf(ovf), .reg_load(reg_load), .reg_clr(reg_clr), .reg_d(reg_d),
        .dbg_state(dbg_state)
    );

    // ---------------- instance B: COUNT=1, ACC_WIDTH=20 ----------------
    logic            s_clear     = 1'b0;
    logic            s_in_valid  = 1'b0;
    logic            s_in_ready;
    logic [W-1:0]    s_a         = '0;
    logic [W-1:0]    s_b         = '0;
    logic            s_out_valid;
    logic            s_out_ready = 1'b1;
    logic [B_AW-1:0] s_result;
    logic            s_ovf;
    logic            s_reg_load;
    logic            s_reg_clr;
    logic [B_AW-1:0] s_reg_d;
    logic            s_dbg_state;

    mac_accum_seq #(.WIDTH(W), .ACC_WIDTH(B_AW), .COUNT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
        .ovf(s_ovf), .reg_load(s_reg_load), .reg_clr(s_reg_clr), .reg_d(s_reg_d),
        .dbg_state(s_dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- scoreboard: model of instance A ----------------
    // One queue entry {ovf, result} per finished group; non-empty means a result is pending.
    logic [A_AW:0] exp_q[$];
    longint        grp_sum = 0;
    int            grp_n   = 0;
    bit            pending, exp_ready, exp_load, exp_clr;
    logic [A_AW:0] ent;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            grp_sum = 0;
            grp_n   = 0;
        end else begin
            pending   = (exp_q.size() != 0);
            exp_ready = !clear && !pending;
            exp_load  = in_valid && exp_ready;
            exp_clr   = clear || (pending && out_ready);
            check("sb_in_ready", in_ready, exp_ready);
            check("sb_out_valid", out_valid, pending);
            check("sb_reg_load", reg_load, exp_load);
            check("sb_reg_clr", reg_clr, exp_clr);
            if (pending) begin
                ent = exp_q[0];
                check("sb_result", result, ent[A_AW-1:0]);
                check("sb_ovf", ovf, ent[A_AW]);
            end
            if (exp_load)
                check("sb_reg_d", reg_d, (grp_sum + longint'(a) * longint'(b)) % (longint'(1) << A_AW));

            if (clear) begin
                exp_q.delete();
                grp_sum = 0;
                grp_n   = 0;
            end else begin
                if (pending && out_ready) void'(exp_q.pop_front());
                if (exp_load) begin
                    grp_sum += longint'(a) * longint'(b);
                    grp_n++;
                    if (grp_n == A_CNT) begin
                        ent[A_AW]       = (grp_sum >= (longint'(1) << A_AW));
                        ent[A_AW-1:0]   = grp_sum[A_AW-1:0];
                        exp_q.push_back(ent);
                        grp_sum = 0;
                        grp_n   = 0;
                    end
                end
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [A_AW-1:0] exp_d;
        logic [A_AW-1:0] exp_res;
        logic            exp_ovf;
    } vec_t;

    vec_t vecs[20];

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [W-1:0] da, input logic [W-1:0] db);
        @(posedge clk);
        #1;
        in_valid = v;
        a        = da;
        b        = db;
    endtask

    // Back-to-back beats lo..hi; the group's result is checked and optionally taken.
    task automatic apply_range(input int lo, input int hi, input bit do_hs);
        for (int i = lo; i <= hi; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b);
            @(negedge clk);
            check("tbl_reg_load", reg_load, 1);
            check("tbl_reg_d", reg_d, vecs[i].exp_d);
        end
        drive(1'b0, '0, '0);
        @(negedge clk);
        check("tbl_out_valid", out_valid, 1);
        check("tbl_result", result, vecs[hi].exp_res);
        check("tbl_ovf", ovf, vecs[hi].exp_ovf);
        if (do_hs) begin
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
            check("tbl_hs_clr", reg_clr, 1);
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check("tbl_hs_ready", in_ready, 1);
            check("tbl_hs_valid", out_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs[0]  = '{8'd3,   8'd4,   16'd12,    16'd100,   1'b0};
        vecs[1]  = '{8'd5,   8'd6,   16'd42,    16'd100,   1'b0};
        vecs[2]  = '{8'd7,   8'd8,   16'd98,    16'd100,   1'b0};
        vecs[3]  = '{8'd1,   8'd2,   16'd100,   16'd100,   1'b0};
        vecs[4]  = '{8'd2,   8'd2,   16'd4,     16'd16,    1'b0};
        vecs[5]  = '{8'd2,   8'd2,   16'd8,     16'd16,    1'b0};
        vecs[6]  = '{8'd2,   8'd2,   16'd12,    16'd16,    1'b0};
        vecs[7]  = '{8'd2,   8'd2,   16'd16,    16'd16,    1'b0};
        vecs[8]  = '{8'd255, 8'd255, 16'd65025, 16'd63492, 1'b1};
        vecs[9]  = '{8'd255, 8'd255, 16'd64514, 16'd63492, 1'b1};
        vecs[10] = '{8'd255, 8'd255, 16'd64003, 16'd63492, 1'b1};
        vecs[11] = '{8'd255, 8'd255, 16'd63492, 16'd63492, 1'b1};
        vecs[12] = '{8'd1,   8'd3,   16'd3,     16'd12,    1'b0};
        vecs[13] = '{8'd1,   8'd3,   16'd6,     16'd12,    1'b0};
        vecs[14] = '{8'd1,   8'd3,   16'd9,     16'd12,    1'b0};
        vecs[15] = '{8'd1,   8'd3,   16'd12,    16'd12,    1'b0};
        vecs[16] = '{8'd1,   8'd1,   16'd1,     16'd4,     1'b0};
        vecs[17] = '{8'd1,   8'd1,   16'd2,     16'd4,     1'b0};
        vecs[18] = '{8'd1,   8'd1,   16'd3,     16'd4,     1'b0};
        vecs[19] = '{8'd1,   8'd1,   16'd4,     16'd4,     1'b0};

        // Reset release and reset state
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_ovf", ovf, 0);

        // Main function, then backpressure on the finished result
        apply_range(0, 3, 1'b0);
        drive(1'b1, 8'd2, 8'd2);
        repeat (5) begin
            @(negedge clk);
            check("bp_result", result, 100);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_reg_load", reg_load, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_reg_clr", reg_clr, 1);
        check("bp_hs_load", reg_load, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bp_clr_pulse", reg_clr, 0);
        apply_range(4, 7, 1'b1);

        // Overflow, then a clean result
        apply_range(8, 11, 1'b1);
        apply_range(12, 15, 1'b1);

        // Clear after two beats with a beat presented in the same cycle
        drive(1'b1, 8'd1, 8'd1);
        drive(1'b1, 8'd1, 8'd1);
        @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        check("clr_in_ready", in_ready, 0);
        check("clr_reg_clr", reg_clr, 1);
        check("clr_reg_load", reg_load, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        apply_range(16, 19, 1'b1);

        // Reset in the middle of an overflowing accumulation
        drive(1'b1, 8'd255, 8'd255);
        drive(1'b1, 8'd255, 8'd255);
        drive(1'b1, 8'd3, 8'd3);
        #1 check("mid_ovf_set", ovf, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_ovf", ovf, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_reg_load", reg_load, 0);
        check("mid_rst_reg_clr", reg_clr, 0);
        check("mid_rst_reg_d", reg_d, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1 check("mid_rel_in_ready", in_ready, 1);

        // Reset while a result is pending drops out_valid without a clock edge
        apply_range(12, 15, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("done_rst_out_valid", out_valid, 0);
        check("done_rst_result", result, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // COUNT=1 instance, out_ready tied high
        @(posedge clk);
        #1;
        s_in_valid = 1'b1;
        s_a        = 8'd10;
        s_b        = 8'd10;
        @(negedge clk);
        check("c1_load0", s_reg_load, 1);
        check("c1_d0", s_reg_d, 100);
        @(posedge clk);
        #1;
        s_a = 8'd3;
        s_b = 8'd3;
        @(negedge clk);
        check("c1_valid0", s_out_valid, 1);
        check("c1_result0", s_result, 100);
        check("c1_ready_done", s_in_ready, 0);
        check("c1_clr0", s_reg_clr, 1);
        @(negedge clk);
        check("c1_pulse0", s_out_valid, 0);
        check("c1_load1", s_reg_load, 1);
        check("c1_d1", s_reg_d, 9);
        @(posedge clk);
        #1 s_in_valid = 1'b0;
        @(negedge clk);
        check("c1_valid1", s_out_valid, 1);
        check("c1_result1", s_result, 9);
        check("c1_ovf1", s_ovf, 0);
        @(negedge clk);
        check("c1_pulse1", s_out_valid, 0);

        // Randomized traffic on instance A, scored by the model
        repeat (600) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = $urandom_range(0, 1) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 15));
            b         = $urandom_range(0, 1) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 19) == 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
